instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit. Holds the program counter, issues word reads to instruction memory over a valid/ready request channel, and accepts in-order responses of variable latency. Buffers returned words with their PC in a small FIFO and presents them to decode as `instrCode` with a valid/ready handshake. Supports PC redirect with flush of buffered and in-flight instructions.

---
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of the control unit. Holds the PC and issues word
// reads to instruction memory. Responses come back in request order with
// variable latency. Returned words are buffered with their PC in a small
// FIFO, which drives decode.
//
// Handshake semantics (every channel): a transfer happens on a rising clock
// edge where valid && ready are both high. A producer holds valid and its
// payload stable until the transfer completes. The only exception is a
// redirect, which withdraws a pending fetch request. The response channel
// has no ready: memory pushes a word whenever imemRspValid is high.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   imemReqValid/Addr     fetch request (Addr is always the current PC)
//   imemReqReady          memory accepts the request
//   imemRspValid/Data     in-order response word
//   instrValid/Code/Pc    FIFO head towards decode (Code/Pc are 0 when empty)
//   instrReady            decode consumes the head
//   redirectValid/Pc      load a new PC and flush everything younger
//   dbg_state             current FSM state (0 = RUN, 1 = FLUSH)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  output logic        instrValid,
  output logic [31:0] instrCode,
  output logic [31:0] instrPc,
  input  logic        instrReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   tag_head;
  logic [PW-1:0]   tag_tail;

  logic [31:0]     fifo_pc  [DEPTH];
  logic [31:0]     fifo_ins [DEPTH];
  logic [31:0]     tag_mem  [DEPTH];

  logic            pop;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic [CW:0]     inflight;
  logic [CW-1:0]   remain;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign instrValid = (count != '0);
  assign pop        = instrValid && instrReady;

  // Credit check. A slot freed by a pop in this cycle is reusable now, so a
  // 1-cycle memory can sustain one instruction per cycle with DEPTH = 2.
  // No underflow is possible: pop implies count >= 1.
  assign inflight = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};

  // Gated by reset so the request is low while reset is held.
  assign imemReqValid = !reset && (state == RUN) && !redirectValid && (inflight < DEPTH_W);
  assign imemReqAddr  = pc;
  assign req_fire     = imemReqValid && imemReqReady;

  // A response with nothing outstanding is spurious and is ignored.
  assign rsp_take = imemRspValid && (outstanding != '0);
  assign push     = rsp_take && (state == RUN) && !redirectValid;

  // These requests are still in flight after a redirect and must be dropped.
  assign remain = outstanding - CW'(rsp_take);

  assign instrCode = instrValid ? fifo_ins[head] : 32'h0;
  assign instrPc   = instrValid ? fifo_pc[head]  : 32'h0;
  assign dbg_state = (state == FLUSH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else if (redirectValid) begin
      pc          <= {redirectPc[31:2], 2'b00};
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
      outstanding <= remain;
      drop_cnt    <= remain;
      state       <= (remain != '0) ? FLUSH : RUN;
    end else begin
      case (state)
        RUN: begin
          if (req_fire) begin
            pc       <= pc + 32'd4;
            tag_tail <= ptr_next(tag_tail);
          end
          if (rsp_take) begin
            tag_head <= ptr_next(tag_head);
            tail     <= ptr_next(tail);
          end
          if (pop) begin
            head <= ptr_next(head);
          end
          outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
          count       <= count + CW'(rsp_take) - CW'(pop);
        end
        FLUSH: begin
          // Every in-flight response belongs to the pre-redirect stream.
          if (rsp_take) begin
            outstanding <= outstanding - CW'(1);
            drop_cnt    <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) begin
              state <= RUN;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Storage for the tag queue and the FIFO. It needs no reset: the pointers
  // and the count qualify every read.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_tail] <= pc;
    end
    if (push) begin
      fifo_pc[tail]  <= tag_mem[tag_head];
      fifo_ins[tail] <= imemRspData;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        reset;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        instrValid;
  logic [31:0] instrCode;
  logic [31:0] instrPc;
  logic        instrReady;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        dbg_state;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .imemReqValid (imemReqValid),
    .imemReqAddr  (imemReqAddr),
    .imemReqReady (imemReqReady),
    .imemRspValid (imemRspValid),
    .imemRspData  (imemRspData),
    .instrValid   (instrValid),
    .instrCode    (instrCode),
    .instrPc      (instrPc),
    .instrReady   (instrReady),
    .redirectValid(redirectValid),
    .redirectPc   (redirectPc),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];     // requests accepted by memory, oldest first
  logic [63:0] exp_q[$];     // {pc, instr} decode must see, oldest first
  logic [31:0] model_pc;
  int          epoch;
  int          cyc;
  int          lat_min;
  int          lat_max;
  bit          data_rand;
  bit          spurious_en;
  bit          exp_rv;

  int tests;
  int fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called just after a rising edge; asserts reset between edges.
  task automatic apply_reset();
    #2;
    reset         = 1'b1;
    imemRspValid  = 1'b0;
    redirectValid = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imemReqValid}, 32'h0);
    chk("rst_req_addr", imemReqAddr, RESET_PC);
    chk("rst_instr_valid", {31'b0, instrValid}, 32'h0);
    chk("rst_instr_code", instrCode, 32'h0);
    chk("rst_instr_pc", instrPc, 32'h0);
    chk("rst_state", {31'b0, dbg_state}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_q.delete();
    exp_q.delete();
    model_pc = RESET_PC;
    epoch++;
  endtask

  // Drives memory at the falling edge, then checks every output against the model.
  task automatic sample();
    bit flushing;
    int room;
    @(negedge clk);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imemRspValid = 1'b1;
      imemRspData  = mem_q[0].data;
    end else if (mem_q.size() == 0 && spurious_en && $urandom_range(0, 3) == 0) begin
      imemRspValid = 1'b1;
      imemRspData  = $urandom;
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = $urandom;
    end
    #1;
    flushing = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) flushing = 1'b1;
    // Buffered + in-flight words may not exceed DEPTH; a pop now frees a slot.
    room = DEPTH - mem_q.size() - exp_q.size() + ((instrReady && exp_q.size() != 0) ? 1 : 0);
    exp_rv = !redirectValid && !flushing && (room > 0);
    chk("req_valid", {31'b0, imemReqValid}, {31'b0, exp_rv});
    chk("req_addr", imemReqAddr, model_pc);
    chk("state", {31'b0, dbg_state}, {31'b0, flushing});
    chk("instr_valid", {31'b0, instrValid}, {31'b0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) begin
      chk("instr_pc", instrPc, exp_q[0][63:32]);
      chk("instr_code", instrCode, exp_q[0][31:0]);
    end else begin
      chk("instr_pc_empty", instrPc, 32'h0);
      chk("instr_code_empty", instrCode, 32'h0);
    end
  endtask

  // Applies this cycle's events to the model, then steps past the rising edge.
  task automatic advance();
    mreq_t e;
    if (!redirectValid && instrReady && exp_q.size() != 0) void'(exp_q.pop_front());
    if (imemRspValid && mem_q.size() != 0) begin
      e = mem_q.pop_front();
      if (!redirectValid && e.epoch == epoch) exp_q.push_back({e.addr, e.data});
    end
    if (exp_rv && imemReqReady) begin
      e.addr  = model_pc;
      e.data  = data_rand ? $urandom : (model_pc ^ 32'hA5A5_0000);
      e.epoch = epoch;
      e.due   = cyc + $urandom_range(lat_max, lat_min);
      mem_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
    if (redirectValid) begin
      exp_q.delete();
      epoch++;
      model_pc = {redirectPc[31:2], 2'b00};
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic set_mem(input int lmin, input int lmax, input bit rnd, input bit spur);
    lat_min     = lmin;
    lat_max     = lmax;
    data_rand   = rnd;
    spurious_en = spur;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pops;
    int hs;
    tests = 0;
    fails = 0;
    cyc = 0;
    epoch = 0;
    model_pc = RESET_PC;
    reset = 1'b1;
    imemReqReady = 1'b0;
    imemRspValid = 1'b0;
    imemRspData = 32'h0;
    instrReady = 1'b0;
    redirectValid = 1'b0;
    redirectPc = 32'h0;
    set_mem(1, 1, 1'b0, 1'b0);

    // Streaming, 1-cycle memory
    apply_reset();
    imemReqReady = 1'b1;
    instrReady = 1'b1;
    pops = 0;
    for (int c = 0; c < 24; c++) begin
      sample();
      if (c == 2) begin
        chk("stream_pc0", instrPc, 32'h0000_0100);
        chk("stream_code0", instrCode, 32'hA5A5_0100);
      end
      if (c == 3) chk("stream_pc1", instrPc, 32'h0000_0104);
      if (c == 4) begin
        chk("stream_pc2", instrPc, 32'h0000_0108);
        chk("stream_code2", instrCode, 32'hA5A5_0108);
      end
      if (c >= 2 && c < 22 && instrValid && instrReady) pops++;
      advance();
    end
    chk("stream_throughput", pops, 20);

    // Backpressure from decode
    apply_reset();
    imemReqReady = 1'b1;
    instrReady = 1'b0;
    hs = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      if (imemReqValid && imemReqReady) hs++;
      advance();
    end
    chk("bp_requests", hs, 2);
    instrReady = 1'b1;
    sample();
    chk("bp_head0", instrPc, 32'h0000_0100);
    chk("bp_next_valid", {31'b0, imemReqValid}, 32'h1);
    chk("bp_next_addr", imemReqAddr, 32'h0000_0108);
    advance();
    sample();
    chk("bp_head1", instrPc, 32'h0000_0104);
    advance();
    run(4);

    // Redirect with two requests in flight on a 3-cycle memory
    set_mem(3, 3, 1'b0, 1'b0);
    apply_reset();
    imemReqReady = 1'b1;
    instrReady = 1'b1;
    run(2);
    redirectValid = 1'b1;
    redirectPc = 32'h0000_0203;
    sample();
    chk("rd_req_dropped", {31'b0, imemReqValid}, 32'h0);
    advance();
    redirectValid = 1'b0;
    sample();
    chk("rd_flush0", {31'b0, dbg_state}, 32'h1);
    advance();
    sample();
    chk("rd_flush1", {31'b0, dbg_state}, 32'h1);
    chk("rd_flush1_noreq", {31'b0, imemReqValid}, 32'h0);
    advance();
    sample();
    chk("rd_back_run", {31'b0, dbg_state}, 32'h0);
    chk("rd_new_valid", {31'b0, imemReqValid}, 32'h1);
    chk("rd_new_addr", imemReqAddr, 32'h0000_0200);
    advance();
    run(10);

    // Redirect coinciding with a response and a pop
    set_mem(1, 1, 1'b0, 1'b0);
    apply_reset();
    imemReqReady = 1'b1;
    instrReady = 1'b1;
    run(6);
    redirectValid = 1'b1;
    redirectPc = 32'h0000_0040;
    sample();
    chk("rc_head_valid", {31'b0, instrValid}, 32'h1);
    advance();
    redirectValid = 1'b0;
    sample();
    chk("rc_fifo_empty", {31'b0, instrValid}, 32'h0);
    chk("rc_no_flush", {31'b0, dbg_state}, 32'h0);
    chk("rc_new_addr", imemReqAddr, 32'h0000_0040);
    chk("rc_new_valid", {31'b0, imemReqValid}, 32'h1);
    advance();
    run(6);

    // Memory stall
    apply_reset();
    imemReqReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      chk("stall_valid", {31'b0, imemReqValid}, 32'h1);
      chk("stall_addr", imemReqAddr, 32'h0000_0100);
      advance();
    end
    imemReqReady = 1'b1;
    sample();
    chk("stall_release_addr", imemReqAddr, 32'h0000_0100);
    advance();
    sample();
    chk("stall_pc_advanced", imemReqAddr, 32'h0000_0104);
    advance();

    // Mid-flight async reset, then PC wrap through a redirect
    set_mem(2, 2, 1'b0, 1'b0);
    run(7);
    set_mem(1, 1, 1'b0, 1'b0);
    apply_reset();
    sample();
    chk("restart_valid", {31'b0, imemReqValid}, 32'h1);
    chk("restart_addr", imemReqAddr, RESET_PC);
    advance();
    redirectValid = 1'b1;
    redirectPc = 32'hFFFF_FFFE;
    sample();
    advance();
    redirectValid = 1'b0;
    sample();
    chk("wrap_addr_top", imemReqAddr, 32'hFFFF_FFFC);
    advance();
    sample();
    chk("wrap_addr_zero", imemReqAddr, 32'h0000_0000);
    chk("wrap_valid", {31'b0, imemReqValid}, 32'h1);
    advance();
    run(6);

    // Randomized traffic against the model
    set_mem(1, 4, 1'b1, 1'b1);
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      imemReqReady = ($urandom_range(0, 3) != 0);
      instrReady = ($urandom_range(0, 9) < 7);
      redirectValid = ($urandom_range(0, 31) == 0);
      redirectPc = $urandom;
      if (c == 1500) begin
        redirectValid = 1'b0;
        apply_reset();
      end
      sample();
      advance();
    end
    redirectValid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
